// File: rtl/m_ext_reservation_station.sv
// Reservation station for the M-extension execution lane.
// Holds up to NUM_SLOTS issued MUL/DIV/REM micro-ops, wakes pending operands
// from the common data bus, and offers the lowest-index ready op to the lane.
//
// Dispatch handshake: dispatch_valid_o/dispatch_ready_i follow strict
// valid/ready semantics. A transfer happens on a rising edge where both are
// high. While valid is low every dispatch data output is driven to zero,
// because the lane ORs the incoming fields into its held copy. The lane does
// not require the offered op to stay stable across a stall, so a lower-index
// slot that becomes ready may replace the current offer.
module m_ext_reservation_station #(
    parameter int XLEN                = 64,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 6,
    parameter int NUM_SLOTS           = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction_i,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index_i,
    input  logic                           issue_1st_ready_i,
    input  logic                           issue_2nd_ready_i,
    input  logic [XLEN-1:0]                issue_1st_value_i,
    input  logic [XLEN-1:0]                issue_2nd_value_i,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_1st_tag_i,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_2nd_tag_i,
    input  logic                           cdb_valid_i,
    input  logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index_i,
    input  logic [XLEN-1:0]                cdb_value_i,
    output logic                           dispatch_valid_o,
    input  logic                           dispatch_ready_i,
    output logic [XLEN-1:0]                dispatch_1st_reg_o,
    output logic [XLEN-1:0]                dispatch_2nd_reg_o,
    output logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction_o,
    output logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index_o
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // Per-slot state
    logic [NUM_SLOTS-1:0]           busy_q;
    logic [DECODED_INSTR_WIDTH-1:0] op_q   [NUM_SLOTS];
    logic [ROB_INDEX_WIDTH-1:0]     rob_q  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]           rdy1_q;
    logic [NUM_SLOTS-1:0]           rdy2_q;
    logic [ROB_INDEX_WIDTH-1:0]     tag1_q [NUM_SLOTS];
    logic [ROB_INDEX_WIDTH-1:0]     tag2_q [NUM_SLOTS];
    logic [XLEN-1:0]                val1_q [NUM_SLOTS];
    logic [XLEN-1:0]                val2_q [NUM_SLOTS];

    logic [SLOT_W-1:0] free_idx;
    logic              any_free;
    logic [SLOT_W-1:0] sel_idx;
    logic              any_cand;
    logic              issue_fire;
    logic              dispatch_fire;
    logic              issue_hit1;
    logic              issue_hit2;

    // Lowest-index free slot and lowest-index ready candidate, from registered state only
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        sel_idx  = '0;
        any_cand = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_idx  = SLOT_W'(i);
                any_cand = 1'b1;
            end
        end
    end

    assign issue_ready_o    = any_free;
    assign dispatch_valid_o = any_cand & ~flush_i;
    assign issue_fire       = issue_valid_i & issue_ready_o & ~flush_i;
    assign dispatch_fire    = dispatch_valid_o & dispatch_ready_i;

    // An issuing operand that is still pending can catch a same-cycle broadcast
    assign issue_hit1 = cdb_valid_i && (issue_1st_tag_i == cdb_ROB_index_i);
    assign issue_hit2 = cdb_valid_i && (issue_2nd_tag_i == cdb_ROB_index_i);

    assign dispatch_1st_reg_o            = dispatch_valid_o ? val1_q[sel_idx] : '0;
    assign dispatch_2nd_reg_o            = dispatch_valid_o ? val2_q[sel_idx] : '0;
    assign dispatch_decoded_instruction_o = dispatch_valid_o ? op_q[sel_idx]  : '0;
    assign dispatch_ROB_index_o          = dispatch_valid_o ? rob_q[sel_idx]  : '0;

    // Slot update: flush wins; otherwise wakeup, dispatch release and issue write share the edge
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                op_q[i]   <= '0;
                rob_q[i]  <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
        end else if (flush_i) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (busy_q[i] && !rdy1_q[i] && cdb_valid_i && (tag1_q[i] == cdb_ROB_index_i)) begin
                    rdy1_q[i] <= 1'b1;
                    val1_q[i] <= cdb_value_i;
                end
                if (busy_q[i] && !rdy2_q[i] && cdb_valid_i && (tag2_q[i] == cdb_ROB_index_i)) begin
                    rdy2_q[i] <= 1'b1;
                    val2_q[i] <= cdb_value_i;
                end
                if (dispatch_fire && (sel_idx == SLOT_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
                // The issue target is a free slot, so it never collides with wakeup or dispatch
                if (issue_fire && (free_idx == SLOT_W'(i))) begin
                    busy_q[i] <= 1'b1;
                    op_q[i]   <= issue_decoded_instruction_i;
                    rob_q[i]  <= issue_ROB_index_i;
                    tag1_q[i] <= issue_1st_tag_i;
                    tag2_q[i] <= issue_2nd_tag_i;
                    rdy1_q[i] <= issue_1st_ready_i | issue_hit1;
                    rdy2_q[i] <= issue_2nd_ready_i | issue_hit2;
                    val1_q[i] <= issue_1st_ready_i ? issue_1st_value_i : cdb_value_i;
                    val2_q[i] <= issue_2nd_ready_i ? issue_2nd_value_i : cdb_value_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_ext_reservation_station.sv
// Bench for m_ext_reservation_station: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model of the station.
module tb_m_ext_reservation_station;

    localparam int XLEN  = 64;
    localparam int R     = 8;
    localparam int D     = 6;
    localparam int NS    = 4;
    localparam int REC_W = 2 + D + R + 2 * XLEN;

    logic          clock_i;
    logic          reset_i;
    logic          flush_i;
    logic          issue_valid_i;
    logic          issue_ready_o;
    logic [D-1:0]  issue_decoded_instruction_i;
    logic [R-1:0]  issue_ROB_index_i;
    logic          issue_1st_ready_i;
    logic          issue_2nd_ready_i;
    logic [XLEN-1:0] issue_1st_value_i;
    logic [XLEN-1:0] issue_2nd_value_i;
    logic [R-1:0]  issue_1st_tag_i;
    logic [R-1:0]  issue_2nd_tag_i;
    logic          cdb_valid_i;
    logic [R-1:0]  cdb_ROB_index_i;
    logic [XLEN-1:0] cdb_value_i;
    logic          dispatch_valid_o;
    logic          dispatch_ready_i;
    logic [XLEN-1:0] dispatch_1st_reg_o;
    logic [XLEN-1:0] dispatch_2nd_reg_o;
    logic [D-1:0]  dispatch_decoded_instruction_o;
    logic [R-1:0]  dispatch_ROB_index_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [REC_W-1:0] exp_q[$];

    m_ext_reservation_station #(
        .XLEN(XLEN), .ROB_INDEX_WIDTH(R), .DECODED_INSTR_WIDTH(D), .NUM_SLOTS(NS)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o),
        .issue_decoded_instruction_i(issue_decoded_instruction_i),
        .issue_ROB_index_i(issue_ROB_index_i),
        .issue_1st_ready_i(issue_1st_ready_i),
        .issue_2nd_ready_i(issue_2nd_ready_i),
        .issue_1st_value_i(issue_1st_value_i),
        .issue_2nd_value_i(issue_2nd_value_i),
        .issue_1st_tag_i(issue_1st_tag_i),
        .issue_2nd_tag_i(issue_2nd_tag_i),
        .cdb_valid_i(cdb_valid_i),
        .cdb_ROB_index_i(cdb_ROB_index_i),
        .cdb_value_i(cdb_value_i),
        .dispatch_valid_o(dispatch_valid_o),
        .dispatch_ready_i(dispatch_ready_i),
        .dispatch_1st_reg_o(dispatch_1st_reg_o),
        .dispatch_2nd_reg_o(dispatch_2nd_reg_o),
        .dispatch_decoded_instruction_o(dispatch_decoded_instruction_o),
        .dispatch_ROB_index_o(dispatch_ROB_index_o)
    );

    // ---------------- clock ----------------
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // ---------------- reference model ----------------
    // Each entry is an op waiting in the station; position = slot index.
    typedef struct packed {
        logic            busy;
        logic [D-1:0]    op;
        logic [R-1:0]    rob;
        logic            rdy1;
        logic            rdy2;
        logic [R-1:0]    tag1;
        logic [R-1:0]    tag2;
        logic [XLEN-1:0] val1;
        logic [XLEN-1:0] val2;
    } ent_t;

    ent_t m_ent [NS];
    ent_t n_ent [NS];

    // Predict this cycle's outputs from the inputs, then commit the next state at the edge
    initial begin
        for (int i = 0; i < NS; i++) m_ent[i] = '0;
        forever begin
            int cand;
            int free;
            logic ev;
            logic eir;
            logic [REC_W-1:0] rec;
            @(negedge clock_i);
            if (reset_i) for (int i = 0; i < NS; i++) m_ent[i] = '0;
            cand = -1;
            free = -1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_ent[i].busy && m_ent[i].rdy1 && m_ent[i].rdy2) cand = i;
                if (!m_ent[i].busy) free = i;
            end
            ev  = (cand >= 0) && !flush_i && !reset_i;
            eir = (free >= 0);
            if (ev)
                rec = {1'b1, eir, m_ent[cand].op, m_ent[cand].rob, m_ent[cand].val1, m_ent[cand].val2};
            else
                rec = {1'b0, eir, {(D + R + 2 * XLEN){1'b0}}};
            exp_q.push_back(rec);

            for (int i = 0; i < NS; i++) n_ent[i] = m_ent[i];
            if (flush_i) begin
                for (int i = 0; i < NS; i++) n_ent[i].busy = 1'b0;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    if (m_ent[i].busy && cdb_valid_i) begin
                        if (!m_ent[i].rdy1 && m_ent[i].tag1 == cdb_ROB_index_i) begin
                            n_ent[i].rdy1 = 1'b1;
                            n_ent[i].val1 = cdb_value_i;
                        end
                        if (!m_ent[i].rdy2 && m_ent[i].tag2 == cdb_ROB_index_i) begin
                            n_ent[i].rdy2 = 1'b1;
                            n_ent[i].val2 = cdb_value_i;
                        end
                    end
                end
                if (ev && dispatch_ready_i) n_ent[cand].busy = 1'b0;
                if (issue_valid_i && eir) begin
                    n_ent[free].busy = 1'b1;
                    n_ent[free].op   = issue_decoded_instruction_i;
                    n_ent[free].rob  = issue_ROB_index_i;
                    n_ent[free].tag1 = issue_1st_tag_i;
                    n_ent[free].tag2 = issue_2nd_tag_i;
                    if (issue_1st_ready_i) begin
                        n_ent[free].rdy1 = 1'b1;
                        n_ent[free].val1 = issue_1st_value_i;
                    end else if (cdb_valid_i && issue_1st_tag_i == cdb_ROB_index_i) begin
                        n_ent[free].rdy1 = 1'b1;
                        n_ent[free].val1 = cdb_value_i;
                    end else begin
                        n_ent[free].rdy1 = 1'b0;
                    end
                    if (issue_2nd_ready_i) begin
                        n_ent[free].rdy2 = 1'b1;
                        n_ent[free].val2 = issue_2nd_value_i;
                    end else if (cdb_valid_i && issue_2nd_tag_i == cdb_ROB_index_i) begin
                        n_ent[free].rdy2 = 1'b1;
                        n_ent[free].val2 = cdb_value_i;
                    end else begin
                        n_ent[free].rdy2 = 1'b0;
                    end
                end
            end
            @(posedge clock_i);
            if (reset_i) for (int i = 0; i < NS; i++) m_ent[i] = '0;
            else         for (int i = 0; i < NS; i++) m_ent[i] = n_ent[i];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            logic [REC_W-1:0] exp_rec;
            logic [REC_W-1:0] act_rec;
            @(negedge clock_i);
            #1;
            act_rec = {dispatch_valid_o, issue_ready_o, dispatch_decoded_instruction_o,
                       dispatch_ROB_index_o, dispatch_1st_reg_o, dispatch_2nd_reg_o};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty t=%0t actual valid=%0b", $time, act_rec[REC_W-1]);
            end else begin
                exp_rec = exp_q.pop_front();
                if (act_rec !== exp_rec) begin
                    n_errors++;
                    $display("FAIL cycle_outputs t=%0t actual v=%0b ir=%0b op=%0h rob=%0h a=%0h b=%0h required v=%0b ir=%0b op=%0h rob=%0h a=%0h b=%0h",
                             $time,
                             act_rec[REC_W-1], act_rec[REC_W-2], act_rec[REC_W-3 -: D],
                             act_rec[2*XLEN +: R], act_rec[XLEN +: XLEN], act_rec[XLEN-1:0],
                             exp_rec[REC_W-1], exp_rec[REC_W-2], exp_rec[REC_W-3 -: D],
                             exp_rec[2*XLEN +: R], exp_rec[XLEN +: XLEN], exp_rec[XLEN-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i               = 1'b0;
        issue_decoded_instruction_i = '0;
        issue_ROB_index_i           = '0;
        issue_1st_ready_i           = 1'b0;
        issue_2nd_ready_i           = 1'b0;
        issue_1st_value_i           = '0;
        issue_2nd_value_i           = '0;
        issue_1st_tag_i             = '0;
        issue_2nd_tag_i             = '0;
        cdb_valid_i                 = 1'b0;
        cdb_ROB_index_i             = '0;
        cdb_value_i                 = '0;
        flush_i                     = 1'b0;
    endtask

    task automatic set_issue(input logic [D-1:0] op, input logic [R-1:0] rob,
                             input logic r1, input logic [XLEN-1:0] v1, input logic [R-1:0] t1,
                             input logic r2, input logic [XLEN-1:0] v2, input logic [R-1:0] t2);
        issue_valid_i               = 1'b1;
        issue_decoded_instruction_i = op;
        issue_ROB_index_i           = rob;
        issue_1st_ready_i           = r1;
        issue_1st_value_i           = v1;
        issue_1st_tag_i             = t1;
        issue_2nd_ready_i           = r2;
        issue_2nd_value_i           = v2;
        issue_2nd_tag_i             = t2;
    endtask

    task automatic set_cdb(input logic [R-1:0] idx, input logic [XLEN-1:0] val);
        cdb_valid_i     = 1'b1;
        cdb_ROB_index_i = idx;
        cdb_value_i     = val;
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog time limit reached at t=%0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        dispatch_ready_i = 1'b0;
        reset_i = 1'b1;
        repeat (2) step();
        reset_i = 1'b0;
        step();

        // Ready operands: one-cycle dispatch of 3/5/7
        dispatch_ready_i = 1'b1;
        set_issue(6'd0, 8'd7, 1'b1, 64'd3, 8'd0, 1'b1, 64'd5, 8'd0);
        step();
        idle();
        repeat (3) step();

        // Pending operand 1 on tag 9, woken two cycles later with 0x10
        set_issue(6'd1, 8'd8, 1'b0, 64'd0, 8'd9, 1'b1, 64'd2, 8'd0);
        step();
        idle();
        repeat (2) step();
        set_cdb(8'd9, 64'h10);
        step();
        idle();
        repeat (2) step();

        // Issue-time bypass on operand 2, tag 4 value 0xFF
        set_issue(6'd2, 8'd10, 1'b1, 64'd6, 8'd0, 1'b0, 64'd0, 8'd4);
        set_cdb(8'd4, 64'hFF);
        step();
        idle();
        repeat (2) step();

        // Fill and drain with ROB 1..4, fifth request held off while full
        dispatch_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_issue(6'd0, R'(k), 1'b1, 64'(k * 11), 8'd0, 1'b1, 64'(k * 13), 8'd0);
            step();
        end
        set_issue(6'd3, 8'd5, 1'b1, 64'd55, 8'd0, 1'b1, 64'd65, 8'd0);
        repeat (3) step();
        idle();
        dispatch_ready_i = 1'b1;
        repeat (6) step();

        // Flush with three busy slots and a concurrent issue
        dispatch_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_issue(6'd1, R'(20 + k), 1'b1, 64'(k), 8'd0, 1'b1, 64'(k + 1), 8'd0);
            step();
        end
        dispatch_ready_i = 1'b1;
        set_issue(6'd2, 8'd30, 1'b1, 64'd1, 8'd0, 1'b1, 64'd2, 8'd0);
        flush_i = 1'b1;
        step();
        idle();
        repeat (4) step();

        // Random traffic with a small tag space so broadcasts hit often
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                set_issue(D'($urandom_range(0, 7)), R'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), {$urandom, $urandom}, R'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), {$urandom, $urandom}, R'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 4)
                set_cdb(R'($urandom_range(0, 7)), {$urandom, $urandom});
            flush_i          = ($urandom_range(0, 59) == 0);
            dispatch_ready_i = ($urandom_range(0, 9) < 6);
            step();
        end
        idle();
        dispatch_ready_i = 1'b1;
        repeat (8) step();

        // Asynchronous reset while an op is being offered
        dispatch_ready_i = 1'b0;
        set_issue(6'd4, 8'd99, 1'b1, 64'hABCD, 8'd0, 1'b1, 64'h1234, 8'd0);
        step();
        idle();
        @(negedge clock_i);
        #3;
        check("offer_before_reset", 64'(dispatch_valid_o), 64'd1);
        reset_i = 1'b1;
        #1;
        check("reset_valid", 64'(dispatch_valid_o), 64'd0);
        check("reset_a", dispatch_1st_reg_o, 64'd0);
        check("reset_b", dispatch_2nd_reg_o, 64'd0);
        check("reset_op", 64'(dispatch_decoded_instruction_o), 64'd0);
        check("reset_rob", 64'(dispatch_ROB_index_o), 64'd0);
        check("reset_issue_ready", 64'(issue_ready_o), 64'd1);
        step();
        reset_i = 1'b0;
        dispatch_ready_i = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
